// File: rtl/cam_cfg_sequencer_if.sv
// Write-request channel between the camera configuration sequencer and the
// SCCB master: valid/ready request with register address and value, then a
// one-cycle done pulse, qualified by nack, once the bus write has finished.
interface cam_cfg_sequencer_if;
  logic       valid;
  logic       ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_val;
  logic       done;
  logic       nack;

  // Sequencer side: issues requests, observes acceptance and completion.
  modport master (
    output valid, reg_addr, reg_val,
    input  ready, done, nack
  );

  // SCCB master side: accepts requests, reports completion.
  modport slave (
    input  valid, reg_addr, reg_val,
    output ready, done, nack
  );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// OV7670 configuration sequencer. Walks a synchronous register ROM of
// {reg_addr, value} words and issues one SCCB write per entry. It honours
// in-table delay markers, retries NACKed writes and stops at the end marker
// or at the last ROM slot. o_cam_done releases the pixel-capture FSM.
module cam_cfg_sequencer #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int DELAY_MS  = 10,
  parameter int ROM_AW    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  cam_cfg_sequencer_if.master sccb,
  output logic              o_busy,
  output logic              o_cam_done,
  output logic              o_err
);

  localparam int DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
  localparam int DCW       = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int RCW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DCW-1:0] DELAY_LOAD  = DCW'(DELAY_CYC - 1);
  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQ     = 3'd3;
  localparam logic [2:0] S_WAIT_WR = 3'd4;
  localparam logic [2:0] S_DELAY   = 3'd5;
  localparam logic [2:0] S_ADVANCE = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]     state;
  logic [RCW-1:0] retry_cnt;
  logic [DCW-1:0] delay_cnt;

  // Sequencer FSM with all outputs registered alongside the state.
  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values, exactly as the flops do in hardware.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      o_rom_addr    <= '0;
      sccb.valid    <= 1'b0;
      sccb.reg_addr <= '0;
      sccb.reg_val  <= '0;
      o_busy        <= 1'b0;
      o_cam_done    <= 1'b0;
      o_err         <= 1'b0;
      retry_cnt     <= '0;
      delay_cnt     <= '0;
    end else begin
      case (state)
        // Start or restart from the first table entry; start is ignored
        // in every other state.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            o_rom_addr <= '0;
            o_cam_done <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b1;
            state      <= S_FETCH;
          end
        end

        // ROM data for the new address is valid one cycle later.
        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          if (i_rom_data == END_MARK) begin
            o_busy     <= 1'b0;
            o_cam_done <= ~o_err;
            state      <= S_DONE;
          end else if (i_rom_data == DELAY_MARK) begin
            delay_cnt <= DELAY_LOAD;
            state     <= S_DELAY;
          end else begin
            sccb.reg_addr <= i_rom_data[15:8];
            sccb.reg_val  <= i_rom_data[7:0];
            retry_cnt     <= '0;
            sccb.valid    <= 1'b1;
            state         <= S_REQ;
          end
        end

        // Hold the request (address/value untouched) until the master
        // takes it.
        S_REQ: begin
          if (sccb.ready) begin
            sccb.valid <= 1'b0;
            state      <= S_WAIT_WR;
          end
        end

        // A NACK re-issues the same write until the retry budget is spent.
        S_WAIT_WR: begin
          if (sccb.done) begin
            if (!sccb.nack) begin
              state <= S_ADVANCE;
            end else if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt  <= retry_cnt + 1'b1;
              sccb.valid <= 1'b1;
              state      <= S_REQ;
            end else begin
              o_err      <= 1'b1;
              o_cam_done <= 1'b0;
              o_busy     <= 1'b0;
              state      <= S_DONE;
            end
          end
        end

        // Counts DELAY_CYC-1 down to 0, i.e. DELAY_CYC cycles in this state.
        S_DELAY: begin
          if (delay_cnt == '0) begin
            state <= S_ADVANCE;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end

        // The last ROM slot ends the table even without an end marker;
        // the address never wraps.
        S_ADVANCE: begin
          if (o_rom_addr == '1) begin
            o_busy     <= 1'b0;
            o_cam_done <= ~o_err;
            state      <= S_DONE;
          end else begin
            o_rom_addr <= o_rom_addr + 1'b1;
            state      <= S_FETCH;
          end
        end

        default: begin
          sccb.valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
